// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor with borrow-in and done pulse
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
);

    // One extra counter bit so the count never wraps inside an operation
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_d;
    logic             bit_br;

    // Full-subtractor cell on the current LSBs of the operand shift registers
    always_comb begin
        bit_d  = a_q[0] ^ b_q[0] ^ br_q;
        bit_br = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

    // Next-state and datapath: latch operands in IDLE, one bit per edge in RUN
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bit_br;
                // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
                res_d = {bit_d, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Diff is only written here, so partial results never show
                    diff_d  = {bit_d, res_q[WIDTH-1:1]};
                    bout_d  = bit_br;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Diff = diff_q;
    assign Bout = bout_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    localparam int WIDTH = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A     = '0;
    logic [WIDTH-1:0] B     = '0;
    logic             Bin   = 1'b0;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             busy;
    logic             done;

    int n_checks   = 0;
    int n_pass     = 0;
    int done_count = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .Diff  (Diff),
        .Bout  (Bout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural model: an accepted start fixes the answer by plain arithmetic,
    // which is published WIDTH edges later for exactly one cycle.
    int m_left = 0;
    bit m_done = 1'b0;
    int m_diff = 0;
    bit m_bout = 1'b0;
    int p_diff = 0;
    bit p_bout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_diff <= 0;
            m_bout <= 1'b0;
            p_diff <= 0;
            p_bout <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_diff <= p_diff;
                m_bout <= p_bout;
            end
        end else if (start) begin
            m_left <= WIDTH;
            p_diff <= (int'(A) - int'(B) - int'(Bin)) & MASK;
            p_bout <= (int'(A) < int'(B) + int'(Bin));
        end
    end

    // Cycle-by-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(busy), 32'(m_left > 0));
            check("done", 32'(done), 32'(m_done));
            check("Diff", 32'(Diff), 32'(m_diff));
            check("Bout", 32'(Bout), 32'(m_bout));
            if (done) done_count++;
        end
    end

    // Starts one operation from a negedge, scrambles the inputs after the sampling
    // edge, and checks latency, busy length and the literal result.
    task automatic do_op(input int a, input int b, input int bin,
                         input int exp_diff, input int exp_bout, input string name);
        int cyc;
        int nb;
        A     = WIDTH'(a);
        B     = WIDTH'(b);
        Bin   = 1'(bin);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = WIDTH'(~a);
        B     = WIDTH'(a + 7);
        Bin   = ~Bin;
        cyc   = 1;
        nb    = int'(busy);
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            nb += int'(busy);
        end
        check({name, "_latency"}, 32'(cyc), 32'(WIDTH + 1));
        check({name, "_busy_cycles"}, 32'(nb), 32'(WIDTH));
        check({name, "_Diff"}, 32'(Diff), 32'(exp_diff));
        check({name, "_Bout"}, 32'(Bout), 32'(exp_bout));
        @(negedge clk);
    endtask

    initial begin
        int d0;
        int cyc;
        time t1;
        time t2;

        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_Diff", 32'(Diff), 32'd0);
        check("reset_Bout", 32'(Bout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(9, 3, 0, 6, 0, "basic");
        do_op(3, 9, 0, 10, 1, "underflow");
        do_op(0, 0, 1, 15, 1, "bin_zero");
        do_op(15, 15, 1, 15, 1, "bin_max");

        // start while busy: second request at E2/E3 must be dropped
        d0    = done_count;
        A     = 4'd9;
        B     = 4'd3;
        Bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A     = 4'd1;
        B     = 4'd1;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("busy_start_done", 32'(done), 32'd1);
        check("busy_start_Diff", 32'(Diff), 32'd6);
        check("busy_start_Bout", 32'(Bout), 32'd0);
        repeat (8) @(negedge clk);
        check("busy_start_single_done", 32'(done_count - d0), 32'd1);

        // reset during RUN aborts the operation
        A     = 4'd9;
        B     = 4'd3;
        Bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_Diff", 32'(Diff), 32'd0);
        check("abort_Bout", 32'(Bout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_count;
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(done_count - d0), 32'd0);
        do_op(5, 2, 0, 3, 0, "after_reset");

        // back-to-back: second start in the IDLE cycle right after done
        A     = 4'd12;
        B     = 4'd5;
        Bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        t1 = $time;
        check("b2b_first_Diff", 32'(Diff), 32'd7);
        check("b2b_first_Bout", 32'(Bout), 32'd0);
        @(negedge clk);
        A     = 4'd5;
        B     = 4'd12;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        t2 = $time;
        check("b2b_second_Diff", 32'(Diff), 32'd9);
        check("b2b_second_Bout", 32'(Bout), 32'd1);
        // five non-done cycles separate the two pulses
        check("b2b_gap_cycles", 32'((t2 - t1) / 10 - 1), 32'd5);
        @(negedge clk);

        // exhaustive sweep against the arithmetic definition
        for (int a = 0; a <= MASK; a++)
            for (int b = 0; b <= MASK; b++)
                for (int bin = 0; bin < 2; bin++)
                    do_op(a, b, bin, (a - b - bin) & MASK, int'(a < b + bin), "sweep");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
